reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order completion tracker that sits between rename/dispatch and the rename alias table (RAT).
//  - Allocates up to MACHINE_WIDTH entries per cycle, in program order.
//  - Returns their ROB addresses, which the RAT uses as its new mapping ids.
//  - Records writeback completion.
//  - Retires up to RELEASE_PORTS completed head entries per cycle, driving the retire interface
//    (valid/id/preg) that the RAT uses to clear stale mappings.
// PARAMETERS
//  ROB_DEPTH      16  entries; power of 2; ROB_DEPTH >= 2*MACHINE_WIDTH
//  MACHINE_WIDTH  2   allocate lanes per cycle
//  RELEASE_PORTS  2   retire lanes per cycle
//  WB_PORTS       2   writeback lanes per cycle
//  AREG_W         5   architectural register index width
//  AW             $clog2(ROB_DEPTH)  ROB address width
// PORTS
//  clk            in   1                    clock; all state changes on posedge
//  reset          in   1                    synchronous, active-high
//  flush          in   1                    discard all entries
//  alloc_valid    in   MACHINE_WIDTH        per-lane allocate request; lanes may be sparse
//  alloc_dst      in   MACHINE_WIDTH*AREG_W destination arch reg per lane (0 = none)
//  alloc_ready    out  1                    allocation accepted this cycle
//  rob_addr_new   out  MACHINE_WIDTH*AW     ROB address for each lane (combinational)
//  wb_valid       in   WB_PORTS             completion strobe
//  wb_rob_addr    in   WB_PORTS*AW          completing entry
//  retire_valid   out  RELEASE_PORTS        registered; lane j retired an entry
//  retire_id      out  RELEASE_PORTS*AREG_W arch dst of retired entry
//  retire_preg    out  RELEASE_PORTS*AW     ROB address of retired entry
//  empty          out  1                    count == 0
//  `ifdef ROB_EXCEPTION_EN:
//  wb_exc         in   WB_PORTS             entry completed with exception
//  exc_valid      out  1                    registered one-cycle pulse
//  exc_rob_addr   out  AW                   ROB address of excepting entry
// BEHAVIOUR
//  State: per-entry valid, complete, dst (+ exc when the macro is defined); head, tail (AW bits,
//   wrap mod ROB_DEPTH); count (AW+1 bits).
//  Reset: head = tail = count = 0; all valid/complete = 0; retire_valid = 0; retire_id = 0;
//   retire_preg = 0; exc_valid = 0; exc_rob_addr = 0; empty = 1.
//  Allocation:
//  - alloc_ready = (count <= ROB_DEPTH - MACHINE_WIDTH), independent of which lanes are valid.
//  - rob_addr_new[i] = tail + (number of valid lanes < i); computed for all lanes, and
//    meaningful only for valid lanes.
//  - When alloc_ready && alloc_valid[i]: at the edge, entry {valid=1, complete=0, dst} is
//    written; tail += popcount(alloc_valid).
//  - When !alloc_ready, nothing is written and rename must hold.
//  Writeback:
//  - wb_valid[k] sets complete[wb_rob_addr[k]] at the edge.
//  - Writeback to an entry with valid = 0 is ignored.
//  - Duplicate addresses on two wb lanes in the same cycle are legal.
//  Retire:
//  - Candidate j = entry (head + j), j < RELEASE_PORTS.
//  - Lane j retires iff lanes 0..j-1 retire, entry is valid, and registered complete = 1.
//  - At the edge: retire_valid[j] <= retire_j; retire_id[j] <= dst; retire_preg[j] <= head+j;
//    the entry's valid is cleared; head += nretire.
//  - Latency: wb_valid at cycle t -> complete visible at t+1 -> retire_valid high from t+2 at
//    the earliest.
//  - Entries with dst = 0 still retire with retire_valid = 1 and retire_id = 0.
//  Count: count_next = count + nalloc - nretire. Allocating into a slot freed by retire in the
//   same cycle is not allowed; alloc_ready uses the pre-retire count.
//  Wrap: head and tail arithmetic is modulo ROB_DEPTH; a retire or allocate group may straddle
//   index ROB_DEPTH-1 -> 0.
//  Full (count = ROB_DEPTH) and empty (count = 0) are both legal; count never exceeds ROB_DEPTH.
//  Flush:
//  - At the edge: all valid/complete cleared, head = tail = count = 0, retire_valid <= 0.
//  - Overrides alloc, wb and retire in the same cycle.
//  - alloc_ready = 0 during a flush cycle.
//  reset has priority over flush. No multi-cycle operation exists, so reset mid-operation
//   simply restores the reset state.
// CONFIGURATION
//  ROB_EXCEPTION_EN defined:
//  - wb_exc is stored with complete.
//  - A head-side candidate with complete = 1 and exc = 1 does not retire, and neither does
//    anything younger than it.
//  - At that edge: exc_valid <= 1 for exactly one cycle; exc_rob_addr <= that entry's address.
//  - Retirement stays blocked, with no repeated pulse, until flush or reset.
//  ROB_EXCEPTION_EN undefined:
//  - wb_exc, exc_valid and exc_rob_addr ports are absent.
//  - Every completed entry retires.
// TESTING
//  1. Reset, then 2 lanes alloc dst=3,5 -> rob_addr_new = 0,1; tail = 2; empty falls the
//     next cycle.
//  2. wb addr 1 at t, wb addr 0 at t+3 -> no retire before t+5; at t+5 both lanes retire:
//     valid = 11, id = {5,3}, preg = {1,0}.
//  3. Alloc until count = 15 -> alloc_ready = 0 with count = 15 > 14; one retire ->
//     count = 14 -> alloc_ready = 1.
//  4. Sparse lanes alloc_valid = 2'b10 at tail = 15 -> lane1 gets addr 15, tail = 0.
//     Then a retire group straddling the wrap emits preg {0,15}.
//  5. flush asserted together with alloc and wb -> the next cycle has count = 0, empty = 1,
//     retire_valid = 0, and stale entries are never retired.
//  6. ROB_EXCEPTION_EN: wb addr 0 with wb_exc = 1, wb addr 1 normal -> exc_valid pulses once
//     with addr 0 and no retire_valid. Flush, then reallocation restarts at addr 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order completion tracker between rename/dispatch and the RAT.
//   Allocates up to MACHINE_WIDTH entries per cycle in program order and returns their ROB
//   addresses. It records writeback completion and retires up to RELEASE_PORTS completed head
//   entries per cycle through a registered retire interface.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             discard every entry (overrides alloc, writeback and retire)
//   alloc_valid/dst   per-lane allocate request and destination arch reg (0 = none)
//   alloc_ready       allocation accepted this cycle (pre-retire occupancy based)
//   rob_addr_new      combinational ROB address per allocate lane
//   wb_valid/rob_addr writeback completion strobes
//   retire_valid/id/preg  registered retire lanes (valid, arch dst, ROB address)
//   empty             no live entries
// Optional feature macro ROB_EXCEPTION_EN adds wb_exc, exc_valid and exc_rob_addr. An excepting
//   head entry blocks retirement and raises a single exc_valid pulse until flush or reset.
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH     = 16,
    parameter int unsigned MACHINE_WIDTH = 2,
    parameter int unsigned RELEASE_PORTS = 2,
    parameter int unsigned WB_PORTS      = 2,
    parameter int unsigned AREG_W        = 5,
    parameter int unsigned AW            = $clog2(ROB_DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [MACHINE_WIDTH-1:0]        alloc_valid,
    input  logic [MACHINE_WIDTH*AREG_W-1:0] alloc_dst,
    output logic                            alloc_ready,
    output logic [MACHINE_WIDTH*AW-1:0]     rob_addr_new,
    input  logic [WB_PORTS-1:0]             wb_valid,
    input  logic [WB_PORTS*AW-1:0]          wb_rob_addr,
`ifdef ROB_EXCEPTION_EN
    input  logic [WB_PORTS-1:0]             wb_exc,
    output logic                            exc_valid,
    output logic [AW-1:0]                   exc_rob_addr,
`endif
    output logic [RELEASE_PORTS-1:0]        retire_valid,
    output logic [RELEASE_PORTS*AREG_W-1:0] retire_id,
    output logic [RELEASE_PORTS*AW-1:0]     retire_preg,
    output logic                            empty
);

    localparam logic [AW:0] ALLOC_LIMIT = (AW+1)'(ROB_DEPTH - MACHINE_WIDTH);

    logic [ROB_DEPTH-1:0]            valid_q, valid_d;
    logic [ROB_DEPTH-1:0]            complete_q, complete_d;
    logic [AREG_W-1:0]               dst_q [ROB_DEPTH];
    logic [AREG_W-1:0]               dst_d [ROB_DEPTH];
    logic [AW-1:0]                   head_q, head_d, tail_q, tail_d;
    logic [AW:0]                     count_q, count_d;
    logic [RELEASE_PORTS-1:0]        retire_valid_q, retire_valid_d;
    logic [RELEASE_PORTS*AREG_W-1:0] retire_id_q, retire_id_d;
    logic [RELEASE_PORTS*AW-1:0]     retire_preg_q, retire_preg_d;
    logic [AW:0]                     nalloc, nretire;
    logic [RELEASE_PORTS-1:0]        retire_go;
`ifdef ROB_EXCEPTION_EN
    logic [ROB_DEPTH-1:0]            exc_q, exc_d;
    logic                            blocked_q, blocked_d;
    logic                            exc_valid_q, exc_valid_d;
    logic [AW-1:0]                   exc_rob_addr_q, exc_rob_addr_d;
    logic                            exc_hit;
    logic [AW-1:0]                   exc_hit_addr;
`endif

    // Allocation: lanes may be sparse, so each lane's address skips only older valid lanes.
    always_comb begin
        alloc_ready = !flush && (count_q <= ALLOC_LIMIT);
        nalloc      = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            rob_addr_new[i*AW +: AW] = tail_q + nalloc[AW-1:0];
            nalloc = nalloc + (AW+1)'(alloc_valid[i]);
        end
    end

    // Retire selection: an in-order chain from head that stops at the first non-retirable entry.
    always_comb begin
        logic          chain;
        logic [AW-1:0] idx;
`ifdef ROB_EXCEPTION_EN
        chain        = !blocked_q;
        exc_hit      = 1'b0;
        exc_hit_addr = '0;
`else
        chain        = 1'b1;
`endif
        idx       = '0;
        nretire   = '0;
        retire_go = '0;
        for (int j = 0; j < RELEASE_PORTS; j++) begin
            idx = head_q + AW'(j);
`ifdef ROB_EXCEPTION_EN
            if (chain && valid_q[idx] && complete_q[idx] && !exc_q[idx]) begin
`else
            if (chain && valid_q[idx] && complete_q[idx]) begin
`endif
                retire_go[j] = 1'b1;
                nretire      = nretire + 1'b1;
            end else begin
`ifdef ROB_EXCEPTION_EN
                // Only the oldest unretired entry may raise the exception.
                if (chain && valid_q[idx] && complete_q[idx]) begin
                    exc_hit      = 1'b1;
                    exc_hit_addr = idx;
                end
`endif
                chain = 1'b0;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] idx;
        idx            = '0;
        valid_d        = valid_q;
        complete_d     = complete_q;
        dst_d          = dst_q;
        head_d         = head_q + nretire[AW-1:0];
        tail_d         = tail_q;
        count_d        = count_q + (alloc_ready ? nalloc : '0) - nretire;
        retire_valid_d = retire_go;
        retire_id_d    = '0;
        retire_preg_d  = '0;
`ifdef ROB_EXCEPTION_EN
        exc_d          = exc_q;
        blocked_d      = blocked_q | exc_hit;
        exc_valid_d    = exc_hit;
        exc_rob_addr_d = exc_hit ? exc_hit_addr : exc_rob_addr_q;
`endif
        if (alloc_ready) begin
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (alloc_valid[i]) begin
                    idx             = rob_addr_new[i*AW +: AW];
                    valid_d[idx]    = 1'b1;
                    complete_d[idx] = 1'b0;
                    dst_d[idx]      = alloc_dst[i*AREG_W +: AREG_W];
`ifdef ROB_EXCEPTION_EN
                    exc_d[idx]      = 1'b0;
`endif
                end
            end
            tail_d = tail_q + nalloc[AW-1:0];
        end
        // Writebacks to free slots are dropped; valid_q excludes slots allocated this cycle.
        for (int k = 0; k < WB_PORTS; k++) begin
            idx = wb_rob_addr[k*AW +: AW];
            if (wb_valid[k] && valid_q[idx]) begin
                complete_d[idx] = 1'b1;
`ifdef ROB_EXCEPTION_EN
                exc_d[idx]      = exc_d[idx] | wb_exc[k];
`endif
            end
        end
        for (int j = 0; j < RELEASE_PORTS; j++) begin
            idx = head_q + AW'(j);
            retire_id_d[j*AREG_W +: AREG_W] = dst_q[idx];
            retire_preg_d[j*AW +: AW]       = idx;
            if (retire_go[j]) begin
                valid_d[idx] = 1'b0;
            end
        end
        if (flush) begin
            valid_d        = '0;
            complete_d     = '0;
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            retire_valid_d = '0;
`ifdef ROB_EXCEPTION_EN
            exc_d          = '0;
            blocked_d      = 1'b0;
            exc_valid_d    = 1'b0;
            exc_rob_addr_d = exc_rob_addr_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= '0;
            complete_q     <= '0;
            dst_q          <= '{default: '0};
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            retire_valid_q <= '0;
            retire_id_q    <= '0;
            retire_preg_q  <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_q          <= '0;
            blocked_q      <= 1'b0;
            exc_valid_q    <= 1'b0;
            exc_rob_addr_q <= '0;
`endif
        end else begin
            valid_q        <= valid_d;
            complete_q     <= complete_d;
            dst_q          <= dst_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            retire_valid_q <= retire_valid_d;
            retire_id_q    <= retire_id_d;
            retire_preg_q  <= retire_preg_d;
`ifdef ROB_EXCEPTION_EN
            exc_q          <= exc_d;
            blocked_q      <= blocked_d;
            exc_valid_q    <= exc_valid_d;
            exc_rob_addr_q <= exc_rob_addr_d;
`endif
        end
    end

    assign retire_valid = retire_valid_q;
    assign retire_id    = retire_id_q;
    assign retire_preg  = retire_preg_q;
    assign empty        = (count_q == '0);
`ifdef ROB_EXCEPTION_EN
    assign exc_valid    = exc_valid_q;
    assign exc_rob_addr = exc_rob_addr_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic for reorder_buffer, checked
//   against a program-order queue model of the live entries.
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int MW    = 2;
    localparam int RP    = 2;
    localparam int WBP   = 2;
    localparam int RW    = 5;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset, flush;
    logic [MW-1:0] alloc_valid;
    logic [MW*RW-1:0] alloc_dst;
    logic          alloc_ready;
    logic [MW*AW-1:0] rob_addr_new;
    logic [WBP-1:0] wb_valid;
    logic [WBP*AW-1:0] wb_rob_addr;
    logic [RP-1:0] retire_valid;
    logic [RP*RW-1:0] retire_id;
    logic [RP*AW-1:0] retire_preg;
    logic          empty;
`ifdef ROB_EXCEPTION_EN
    logic [WBP-1:0] wb_exc;
    logic          exc_valid;
    logic [AW-1:0] exc_rob_addr;
`endif

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_dst    (alloc_dst),
        .alloc_ready  (alloc_ready),
        .rob_addr_new (rob_addr_new),
        .wb_valid     (wb_valid),
        .wb_rob_addr  (wb_rob_addr),
`ifdef ROB_EXCEPTION_EN
        .wb_exc       (wb_exc),
        .exc_valid    (exc_valid),
        .exc_rob_addr (exc_rob_addr),
`endif
        .retire_valid (retire_valid),
        .retire_id    (retire_id),
        .retire_preg  (retire_preg),
        .empty        (empty)
    );

    // Live entries in program order; the front is the head.
    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] dst;
        bit            done;
        bit            exc;
    } ent_t;

    ent_t         q[$];
    int           m_head;
    bit           m_blocked;
    logic [RP-1:0] m_rv;
    logic [RP*RW-1:0] m_id;
    logic [RP*AW-1:0] m_preg;
    bit           m_exc;
    logic [AW-1:0] m_exc_addr;
    int           n_vec = 0;
    int           n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_head    = 0;
        m_blocked = 0;
        m_rv      = '0;
        m_exc     = 0;
    endtask

    // One clock: check outputs at negedge, advance the model, then cross the posedge.
    task automatic step();
        int   tail, off, nret;
        bit   ready, stop;
        ent_t e;
        @(negedge clk);
        ready = !flush && (q.size() <= DEPTH - MW);
        tail  = (m_head + q.size()) % DEPTH;
        check_eq("alloc_ready", 32'(alloc_ready), 32'(ready));
        check_eq("empty", 32'(empty), 32'(q.size() == 0));
        off = 0;
        for (int i = 0; i < MW; i++) begin
            if (alloc_valid[i]) begin
                check_eq("rob_addr_new", 32'(rob_addr_new[i*AW +: AW]), 32'((tail + off) % DEPTH));
                off++;
            end
        end
        check_eq("retire_valid", 32'(retire_valid), 32'(m_rv));
        for (int j = 0; j < RP; j++) begin
            if (m_rv[j]) begin
                check_eq("retire_id", 32'(retire_id[j*RW +: RW]), 32'(m_id[j*RW +: RW]));
                check_eq("retire_preg", 32'(retire_preg[j*AW +: AW]), 32'(m_preg[j*AW +: AW]));
            end
        end
`ifdef ROB_EXCEPTION_EN
        check_eq("exc_valid", 32'(exc_valid), 32'(m_exc));
        if (m_exc) check_eq("exc_rob_addr", 32'(exc_rob_addr), 32'(m_exc_addr));
`endif
        if (reset) begin
            model_clear();
            m_id       = '0;
            m_preg     = '0;
            m_exc_addr = '0;
        end else if (flush) begin
            model_clear();
        end else begin
            stop  = m_blocked;
            m_rv  = '0;
            m_exc = 0;
            nret  = 0;
            for (int j = 0; j < RP; j++) begin
                if (!stop && j < q.size() && q[j].done) begin
                    if (q[j].exc) begin
                        m_exc      = 1;
                        m_exc_addr = q[j].addr;
                        m_blocked  = 1;
                        stop       = 1;
                    end else begin
                        m_rv[j]            = 1'b1;
                        m_id[j*RW +: RW]   = q[j].dst;
                        m_preg[j*AW +: AW] = q[j].addr;
                        nret++;
                    end
                end else begin
                    stop = 1;
                end
            end
            for (int k = 0; k < WBP; k++) begin
                if (wb_valid[k]) begin
                    for (int n = 0; n < q.size(); n++) begin
                        if (q[n].addr == wb_rob_addr[k*AW +: AW]) begin
                            q[n].done = 1;
`ifdef ROB_EXCEPTION_EN
                            q[n].exc = q[n].exc | wb_exc[k];
`endif
                        end
                    end
                end
            end
            repeat (nret) void'(q.pop_front());
            m_head = (m_head + nret) % DEPTH;
            if (ready) begin
                off = 0;
                for (int i = 0; i < MW; i++) begin
                    if (alloc_valid[i]) begin
                        e.addr = AW'((tail + off) % DEPTH);
                        e.dst  = alloc_dst[i*RW +: RW];
                        e.done = 0;
                        e.exc  = 0;
                        q.push_back(e);
                        off++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [1:0] av, input logic [9:0] dst, input logic [1:0] wv,
                       input logic [7:0] wa, input logic fl);
        alloc_valid = av;
        alloc_dst   = dst;
        wb_valid    = wv;
        wb_rob_addr = wa;
        flush       = fl;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 10'd0, 2'b00, 8'h00, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        alloc_valid = '0;
        alloc_dst   = '0;
        wb_valid    = '0;
        wb_rob_addr = '0;
`ifdef ROB_EXCEPTION_EN
        wb_exc      = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        m_id       = '0;
        m_preg     = '0;
        m_exc_addr = '0;
        reset      = 1'b0;
        check_eq("rst_retire_id", 32'(retire_id), 32'd0);
        check_eq("rst_retire_preg", 32'(retire_preg), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);

        // Two-lane allocate after reset.
        cyc(2'b11, {5'd5, 5'd3}, 2'b00, 8'h00, 1'b0);
        check_eq("t1_empty", 32'(empty), 32'd0);
        check_eq("t1_tail", 32'(rob_addr_new[3:0]), 32'd2);

        // Out-of-order writeback; retire waits for the head.
        cyc(2'b00, 10'd0, 2'b01, 8'h01, 1'b0);
        idle(2);
        cyc(2'b00, 10'd0, 2'b01, 8'h00, 1'b0);
        check_eq("t2_early", 32'(retire_valid), 32'd0);
        idle(1);
        check_eq("t2_valid", 32'(retire_valid), 32'd3);
        check_eq("t2_id", 32'(retire_id), 32'({5'd5, 5'd3}));
        check_eq("t2_preg", 32'(retire_preg), 32'h10);

        // Fill to 15 entries, then free one.
        for (int i = 0; i < 7; i++) cyc(2'b11, 10'($urandom), 2'b00, 8'h00, 1'b0);
        cyc(2'b01, 10'd9, 2'b00, 8'h00, 1'b0);
        check_eq("t3_full", 32'(alloc_ready), 32'd0);
        cyc(2'b00, 10'd0, 2'b01, 8'h02, 1'b0);
        check_eq("t3_still_full", 32'(alloc_ready), 32'd0);
        idle(1);
        check_eq("t3_ready", 32'(alloc_ready), 32'd1);

        // Wrap: sparse allocate at tail 15, then a straddling retire group.
        cyc(2'b00, 10'd0, 2'b00, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) cyc(2'b11, 10'($urandom), 2'b00, 8'h00, 1'b0);
        cyc(2'b01, 10'd4, 2'b00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cyc(2'b00, 10'd0, 2'b11, {4'(2*i+1), 4'(2*i)}, 1'b0);
        idle(10);
        check_eq("t4_drained", 32'(empty), 32'd1);
        alloc_valid = 2'b10;
        #1;
        check_eq("t4_lane1", 32'(rob_addr_new[7:4]), 32'd15);
        cyc(2'b10, {5'd7, 5'd0}, 2'b00, 8'h00, 1'b0);
        cyc(2'b11, {5'd2, 5'd1}, 2'b00, 8'h00, 1'b0);
        cyc(2'b00, 10'd0, 2'b11, {4'd0, 4'd15}, 1'b0);
        idle(1);
        check_eq("t4_wrap_valid", 32'(retire_valid), 32'd3);
        check_eq("t4_wrap_preg", 32'(retire_preg), 32'h0F);

        // Flush beats a simultaneous alloc and writeback.
        cyc(2'b11, 10'd33, 2'b01, 8'h01, 1'b1);
        check_eq("t5_empty", 32'(empty), 32'd1);
        check_eq("t5_retire", 32'(retire_valid), 32'd0);
        idle(4);

`ifdef ROB_EXCEPTION_EN
        cyc(2'b11, {5'd6, 5'd4}, 2'b00, 8'h00, 1'b0);
        wb_exc = 2'b01;
        cyc(2'b00, 10'd0, 2'b11, {4'd1, 4'd0}, 1'b0);
        wb_exc = 2'b00;
        idle(1);
        check_eq("t6_exc", 32'(exc_valid), 32'd1);
        check_eq("t6_exc_addr", 32'(exc_rob_addr), 32'd0);
        check_eq("t6_no_retire", 32'(retire_valid), 32'd0);
        idle(1);
        check_eq("t6_pulse_once", 32'(exc_valid), 32'd0);
        idle(2);
        cyc(2'b00, 10'd0, 2'b00, 8'h00, 1'b1);
        alloc_valid = 2'b01;
        #1;
        check_eq("t6_realloc", 32'(rob_addr_new[3:0]), 32'd0);
        cyc(2'b01, 10'd8, 2'b00, 8'h00, 1'b0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(0, 499) == 0);
            flush       = ($urandom_range(0, 63) == 0);
            alloc_valid = 2'($urandom);
            alloc_dst   = 10'($urandom);
            for (int k = 0; k < WBP; k++) begin
                wb_valid[k] = ($urandom_range(0, 2) != 0);
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_rob_addr[k*AW +: AW] = q[$urandom_range(0, q.size() - 1)].addr;
                else
                    wb_rob_addr[k*AW +: AW] = 4'($urandom);
`ifdef ROB_EXCEPTION_EN
                wb_exc[k] = ($urandom_range(0, 39) == 0);
`endif
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
